pu_scheduler: RTL

PU_SCHEDULER -- requirements
Module: pu_scheduler

---
 rtl/pu_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pu_scheduler.sv
// pu_scheduler: sequences weight rows into a pipelined PU and writes each result back to the feedback buffer.
// Job timing: NUM_OUT issue cycles, then PIPE_LAT drain cycles, then one check cycle per pass; done pulses one cycle after the last check.
// No backpressure: the PU must accept one row per cycle. A start outside IDLE is ignored. Optional macro PU_SCHED_EARLY_STOP_EN enables early stop.
module pu_scheduler #(
  parameter int NUM_OUT  = 4,  // rows per pass, 1..16
  parameter int PIPE_LAT = 2   // PU latency in cycles, must be >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  iter_limit,
  input  logic [11:0] pu_result,
  output logic        pu_issue,
  output logic [3:0]  weight_addr,
  output logic        in_sel,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [3:0]  pass_cnt,
  output logic        busy,
  output logic        done,
  output logic        converged
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int          DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [3:0]  LAST_ROW   = 4'(NUM_OUT - 1);

  state_t        state_q, state_d;
  logic          pu_issue_q, pu_issue_d;
  logic [3:0]    weight_addr_q, weight_addr_d;
  logic          in_sel_q, in_sel_d;
  logic [3:0]    pass_cnt_q, pass_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    limit_q, limit_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;

  // Write-back pipe: issue/row delayed by the PU latency so writes line up with results
  logic [PIPE_LAT-1:0]      issue_pipe_q, issue_pipe_d;
  logic [PIPE_LAT-1:0][3:0] addr_pipe_q, addr_pipe_d;

  logic pass_start;  // a new pass begins next cycle
  logic early_stop;  // pass produced too few positive results to continue

  // Next-state and registered-output values of the pass sequencer
  always_comb begin
    state_d       = state_q;
    pu_issue_d    = 1'b0;
    weight_addr_d = 4'd0;
    in_sel_d      = in_sel_q;
    pass_cnt_d    = pass_cnt_q;
    done_d        = 1'b0;
    limit_d       = limit_q;
    drain_cnt_d   = drain_cnt_q;
    pass_start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_ISSUE;
          pass_cnt_d    = 4'd0;
          in_sel_d      = 1'b0;
          limit_d       = (iter_limit == 4'd0) ? 4'd1 : iter_limit;
          pu_issue_d    = 1'b1;
          weight_addr_d = 4'd0;
          pass_start    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (weight_addr_q == LAST_ROW) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          pu_issue_d    = 1'b1;
          weight_addr_d = weight_addr_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_CHECK;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        pass_cnt_d = pass_cnt_q + 4'd1;
        if ((pass_cnt_d == limit_q) || early_stop) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d       = S_ISSUE;
          in_sel_d      = 1'b1;
          pu_issue_d    = 1'b1;
          weight_addr_d = 4'd0;
          pass_start    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Shift the issued row down the write-back pipe
  always_comb begin
    issue_pipe_d    = issue_pipe_q;
    addr_pipe_d     = addr_pipe_q;
    issue_pipe_d[0] = pu_issue_q;
    addr_pipe_d[0]  = weight_addr_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      issue_pipe_d[i] = issue_pipe_q[i-1];
      addr_pipe_d[i]  = addr_pipe_q[i-1];
    end
  end

  // Sequencer and write-back state; reset also flushes any in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pu_issue_q    <= 1'b0;
      weight_addr_q <= 4'd0;
      in_sel_q      <= 1'b0;
      pass_cnt_q    <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      limit_q       <= 4'd0;
      drain_cnt_q   <= '0;
      issue_pipe_q  <= '0;
      addr_pipe_q   <= '0;
    end else begin
      state_q       <= state_d;
      pu_issue_q    <= pu_issue_d;
      weight_addr_q <= weight_addr_d;
      in_sel_q      <= in_sel_d;
      pass_cnt_q    <= pass_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      limit_q       <= limit_d;
      drain_cnt_q   <= drain_cnt_d;
      issue_pipe_q  <= issue_pipe_d;
      addr_pipe_q   <= addr_pipe_d;
    end
  end

  assign pu_issue    = pu_issue_q;
  assign weight_addr = weight_addr_q;
  assign in_sel      = in_sel_q;
  assign wr_en       = issue_pipe_q[PIPE_LAT-1];
  assign wr_addr     = addr_pipe_q[PIPE_LAT-1];
  assign pass_cnt    = pass_cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef PU_SCHED_EARLY_STOP_EN
  logic [4:0] pos_cnt_q, pos_cnt_d;
  logic       converged_q, converged_d;

  // Count strictly positive results written this pass; flag convergence on the final check
  always_comb begin
    pos_cnt_d = pos_cnt_q;
    if (pass_start) begin
      pos_cnt_d = 5'd0;
    end else if (wr_en && !pu_result[11] && (pu_result != 12'd0)) begin
      pos_cnt_d = pos_cnt_q + 5'd1;
    end
    converged_d = (state_q == S_CHECK) && early_stop;
  end

  // Positive-result counter and convergence flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_cnt_q   <= 5'd0;
      converged_q <= 1'b0;
    end else begin
      pos_cnt_q   <= pos_cnt_d;
      converged_q <= converged_d;
    end
  end

  assign early_stop = (pos_cnt_q <= 5'd1);
  assign converged  = converged_q;
`else
  // Without early stop the result value never influences sequencing
  logic pu_result_unused;
  assign pu_result_unused = ^{pu_result, pass_start};
  assign early_stop       = 1'b0;
  assign converged        = 1'b0;
`endif

endmodule
